// File: rtl/s2p_rx.sv
// s2p_rx: serial-to-parallel receiver for the segment/LED serial link.
//
// Rebuilds the parallel frame sent by the parallel-to-serial transmitter.
// All four serial-link inputs are resynchronised to clk. Edges are then
// detected on the synchronised copies.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   sclk       serial shift clock; each rising edge carries one bit on sin
//   sin        serial data, MSB (bit WIDTH-1) first
//   pen        latch enable; a rising edge closes the open frame
//   sclrn      active-low clear of the serial chain (also clears pdata)
//   pdata      last correctly received frame
//   valid      one-cycle pulse when pdata is updated
//   frame_err  one-cycle pulse when a frame is rejected (bad length,
//              overrun or timeout)
//   busy       high while a frame is open (FSM in SHIFT); this is the
//              FSM state as seen from outside
//   bit_cnt    bits received in the current frame, saturating at WIDTH
module s2p_rx #(
    parameter int WIDTH       = 64,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       sin,
    input  logic                       pen,
    input  logic                       sclrn,
    output logic [WIDTH-1:0]           pdata,
    output logic                       valid,
    output logic                       frame_err,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchroniser chain. Each stage is {sclrn, pen, sin, sclk}.
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_d [SYNC_STAGES];
    // Edge-detect delay register: {pen, sclk} one cycle behind the last stage.
    logic [1:0] prev_q, prev_d;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic s_sclk, s_sin, s_pen, s_sclrn;
    logic sclk_rise, pen_rise;

    always_comb begin
        sync_d[0] = {sclrn, pen, sin, sclk};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign s_sclk  = sync_q[SYNC_STAGES-1][0];
    assign s_sin   = sync_q[SYNC_STAGES-1][1];
    assign s_pen   = sync_q[SYNC_STAGES-1][2];
    assign s_sclrn = sync_q[SYNC_STAGES-1][3];

    assign prev_d    = {s_pen, s_sclk};
    assign sclk_rise = s_sclk & ~prev_q[0];
    assign pen_rise  = s_pen & ~prev_q[1];

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        tmr_d   = tmr_q;
        pdata_d = pdata_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (!s_sclrn) begin
            // Clear wins over everything; edges seen meanwhile are dropped
            // but prev_q keeps tracking so no stale edge appears afterwards.
            pdata_d = '0;
            sreg_d  = '0;
            cnt_d   = '0;
            ovr_d   = 1'b0;
            tmr_d   = '0;
            state_d = IDLE;
        end else begin
            // The shift happens first so a latch coinciding with the final
            // bit sees the updated count and overrun flag.
            if (sclk_rise) begin
                sreg_d = {sreg_q[WIDTH-2:0], s_sin};
                if (cnt_q == CW'(WIDTH)) begin
                    ovr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (sclk_rise) begin
                        state_d = SHIFT;
                        tmr_d   = '0;
                    end
                end
                SHIFT: begin
                    tmr_d = sclk_rise ? '0 : tmr_q + TW'(1);
                    if (pen_rise) begin
                        if (cnt_d == CW'(WIDTH) && !ovr_d) begin
                            pdata_d = sreg_d;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        cnt_d   = '0;
                        ovr_d   = 1'b0;
                        tmr_d   = '0;
                        state_d = IDLE;
                    end else if (!sclk_rise && tmr_q == TW'(TIMEOUT - 1)) begin
                        // Transmitter went quiet mid-frame: abandon it.
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        ovr_d   = 1'b0;
                        tmr_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q  <= '0;
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            tmr_q   <= '0;
            pdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q  <= prev_d;
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            tmr_q   <= tmr_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign pdata     = pdata_q;
    assign valid     = valid_q;
    assign frame_err = err_q;
    assign busy      = (state_q == SHIFT);
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_s2p_rx.sv
// tb_s2p_rx: self-checking bench for s2p_rx.
// The reference model keeps the bits of the open frame in a queue and
// decides the outcome of each latch from the queue length alone. Expected
// pulses (bit WIDTH = 1 for frame_err, 0 for valid, low bits = pdata) are
// queued at stimulus time and popped by an independent monitor.
module tb_s2p_rx;

    localparam int WIDTH   = 64;
    localparam int TIMEOUT = 1024;
    localparam int CW      = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             sclk;
    logic             sin;
    logic             pen;
    logic             sclrn;
    logic [WIDTH-1:0] pdata;
    logic             valid;
    logic             frame_err;
    logic             busy;
    logic [CW-1:0]    bit_cnt;

    s2p_rx #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sin      (sin),
        .pen      (pen),
        .sclrn    (sclrn),
        .pdata    (pdata),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy),
        .bit_cnt  (bit_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [WIDTH:0]   exp_q[$];
    logic             m_bits[$];
    logic             m_open;
    logic [WIDTH-1:0] m_pdata;
    int               n_checks;
    int               n_fail;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] pack_bits();
        logic [WIDTH-1:0] v = '0;
        foreach (m_bits[i]) v = {v[WIDTH-2:0], m_bits[i]};
        return v;
    endfunction

    task automatic model_latch();
        if (m_open) begin
            if (m_bits.size() == WIDTH) begin
                m_pdata = pack_bits();
                exp_q.push_back({1'b0, m_pdata});
            end else begin
                exp_q.push_back({1'b1, m_pdata});
            end
        end
        m_bits.delete();
        m_open = 1'b0;
    endtask

    task automatic model_timeout();
        if (m_open) exp_q.push_back({1'b1, m_pdata});
        m_bits.delete();
        m_open = 1'b0;
    endtask

    task automatic model_clear();
        m_pdata = '0;
        m_bits.delete();
        m_open = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        m_bits.push_back(b);
        m_open = 1'b1;
        repeat (2) @(negedge clk);
        sclk = 1'b0;
    endtask

    // Sends n bits of d MSB-first; bits beyond WIDTH are random.
    task automatic send_bits(input logic [WIDTH-1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < WIDTH) send_bit(d[WIDTH-1-i]);
            else           send_bit(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic pulse_pen();
        @(negedge clk);
        pen = 1'b1;
        model_latch();
        repeat (3) @(negedge clk);
        pen = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Final bit's sclk rise and the pen rise reach the pins together.
    task automatic last_bit_with_pen(input logic b);
        @(negedge clk);
        sin = b;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        pen  = 1'b1;
        m_bits.push_back(b);
        m_open = 1'b1;
        model_latch();
        repeat (3) @(negedge clk);
        sclk = 1'b0;
        pen  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] d);
        send_bits(d, WIDTH);
        pulse_pen();
    endtask

    // Waits (bounded) for every queued expectation to be consumed.
    task automatic drain(input string name, input int max_cycles);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        repeat (5) @(negedge clk);
        check(name, WIDTH'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [WIDTH:0] e;
        #1;
        if (valid || frame_err) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%b frame_err=%b pdata=%h expected none at %0t",
                         valid, frame_err, pdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", WIDTH'({valid, frame_err}),
                      e[WIDTH] ? WIDTH'(2'b01) : WIDTH'(2'b10));
                check("pulse_pdata", pdata, e[WIDTH-1:0]);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] rd;
        int               len;
        n_checks = 0;
        n_fail   = 0;
        m_open   = 1'b0;
        m_pdata  = '0;
        rst   = 1'b1;
        sclk  = 1'b0;
        sin   = 1'b0;
        pen   = 1'b0;
        sclrn = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pdata",     pdata,            '0);
        check("rst_valid",     WIDTH'(valid),     '0);
        check("rst_frame_err", WIDTH'(frame_err), '0);
        check("rst_busy",      WIDTH'(busy),      '0);
        check("rst_bit_cnt",   WIDTH'(bit_cnt),   '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Good frame.
        send_frame(64'h0123_4567_89AB_CDEF);
        drain("drain_good", 50);
        check("good_bit_cnt", WIDTH'(bit_cnt), '0);
        check("good_busy",    WIDTH'(busy),    '0);

        // Short frame.
        send_bits('1, WIDTH - 1);
        pulse_pen();
        drain("drain_short", 50);

        // Overlong frame: count saturates.
        send_bits(64'h1357_9BDF_0246_8ACE, WIDTH + 1);
        repeat (4) @(negedge clk);
        check("sat_bit_cnt", WIDTH'(bit_cnt), WIDTH'(WIDTH));
        check("sat_busy",    WIDTH'(busy),    WIDTH'(1));
        pulse_pen();
        drain("drain_long", 50);

        // Timeout mid-frame, then a clean frame.
        send_bits(64'hFFC0_0000_0000_0000, 10);
        model_timeout();
        drain("drain_timeout", TIMEOUT + 200);
        check("timeout_busy",    WIDTH'(busy),    '0);
        check("timeout_bit_cnt", WIDTH'(bit_cnt), '0);
        send_frame(64'hA5A5_A5A5_5A5A_5A5A);
        drain("drain_after_timeout", 50);

        // Clear mid-frame.
        send_bits(64'h1111_2222_3333_4444, 32);
        @(negedge clk);
        sclrn = 1'b0;
        model_clear();
        repeat (4) @(negedge clk);
        sclrn = 1'b1;
        repeat (4) @(negedge clk);
        check("clr_pdata",   pdata,           '0);
        check("clr_bit_cnt", WIDTH'(bit_cnt), '0);
        check("clr_busy",    WIDTH'(busy),    '0);
        send_frame(64'hDEAD_BEEF_CAFE_F00D);
        drain("drain_after_clear", 50);

        // Last bit coincides with the latch.
        rd = 64'h8000_0000_0000_0001;
        send_bits(rd, WIDTH - 1);
        last_bit_with_pen(rd[0]);
        drain("drain_coincident", 50);

        // Randomized frames of assorted lengths, with an occasional clear.
        for (int f = 0; f < 8; f++) begin
            rd = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       len = WIDTH - 1;
                1:       len = WIDTH + 1;
                2:       len = $urandom_range(1, WIDTH - 2);
                default: len = WIDTH;
            endcase
            send_bits(rd, len);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                sclrn = 1'b0;
                model_clear();
                repeat (3) @(negedge clk);
                sclrn = 1'b1;
                repeat (4) @(negedge clk);
            end else begin
                pulse_pen();
            end
            drain("drain_random", 50);
        end

        // Reset mid-frame after a good frame left pdata non-zero.
        send_frame(64'hFEDC_BA98_7654_3210);
        drain("drain_pre_rst", 50);
        send_bits(64'hF0F0_F0F0_F0F0_F0F0, 20);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        check("midrst_pdata",     pdata,            '0);
        check("midrst_valid",     WIDTH'(valid),     '0);
        check("midrst_frame_err", WIDTH'(frame_err), '0);
        check("midrst_busy",      WIDTH'(busy),      '0);
        check("midrst_bit_cnt",   WIDTH'(bit_cnt),   '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(64'h0F1E_2D3C_4B5A_6978);
        drain("drain_after_rst", 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
